// File: rtl/card_dealer.sv
// Random card dealer for multi-deck shoes: one card per req/ack handshake, drawn without
// replacement. Optional statistics outputs are enabled with `define CARD_DEALER_STATS_EN.
module card_dealer #(
    parameter int          NUM_DECKS = 1,
    parameter int          NUM_SUITS = 4,
    parameter int          NUM_RANKS = 13,
    parameter int          MAX_TRIES = 8,
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    localparam int         TOTAL     = NUM_DECKS * NUM_SUITS * NUM_RANKS,
    localparam int         CL_W      = $clog2(TOTAL + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            shuffle,
    output logic            ack,
    output logic            nack,
    output logic [1:0]      card_suit,
    output logic [3:0]      card_rank,
    output logic [3:0]      card_value,
    output logic [CL_W-1:0] cards_left,
    output logic            empty,
    output logic            busy
`ifdef CARD_DEALER_STATS_EN
    ,
    output logic [7:0]      deal_cycles,
    output logic [0:0]      scanned
`endif
);

    localparam int SLOTS  = NUM_SUITS * NUM_RANKS;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int UC_W   = $clog2(NUM_DECKS + 1);
    localparam int TRY_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    localparam logic [TRY_W-1:0] TRY_LAST  = TRY_W'(MAX_TRIES - 1);
    localparam logic [UC_W-1:0]  USE_LIMIT = UC_W'(NUM_DECKS);
    localparam logic [3:0]       RANK_LAST = 4'(NUM_RANKS - 1);
    localparam logic [1:0]       SUIT_LAST = 2'(NUM_SUITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_SCAN,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [TRY_W-1:0]    try_q, try_d;
    logic [1:0]          scan_suit_q, scan_suit_d;
    logic [3:0]          scan_rank_q, scan_rank_d;
    logic [7:0]          lfsr_q, lfsr_d;
    logic [UC_W-1:0]     cnt_q [SLOTS];
    logic [UC_W-1:0]     cnt_d [SLOTS];
    logic [CL_W-1:0]     cards_left_q, cards_left_d;
    logic                ack_q, ack_d;
    logic                nack_q, nack_d;
    logic [1:0]          suit_q, suit_d;
    logic [3:0]          rank_q, rank_d;
    logic [3:0]          value_q, value_d;
`ifdef CARD_DEALER_STATS_EN
    logic [7:0]          cyc_q, cyc_d;
    logic [7:0]          deal_cycles_q, deal_cycles_d;
    logic                scanned_q, scanned_d;
`endif

    logic [SLOTS-1:0]    free_vec;
    logic [3:0]          samp_rank;
    logic [1:0]          samp_suit;
    logic                samp_ok;
    logic                scan_ok;
    logic                deal;
    logic [1:0]          deal_suit;
    logic [3:0]          deal_rank;
    logic [SLOT_W-1:0]   deal_idx;
    logic                empty_w;

    function automatic logic [SLOT_W-1:0] slot_of(input logic [1:0] s, input logic [3:0] r);
        return SLOT_W'(int'(s) * NUM_RANKS + int'(r));
    endfunction

    function automatic logic [3:0] value_of(input logic [3:0] r);
        return (r >= 4'd9) ? 4'd10 : r + 4'd1;
    endfunction

    assign empty_w   = (cards_left_q == '0);
    assign samp_rank = lfsr_q[3:0];
    assign samp_suit = lfsr_q[5:4];

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            free_vec[i] = (cnt_q[i] < USE_LIMIT);
        end
    end

    // The slot lookup is only meaningful once the sample is known to be in range.
    assign samp_ok = ({1'b0, samp_rank} < 5'(NUM_RANKS)) &&
                     ({1'b0, samp_suit} < 3'(NUM_SUITS)) &&
                     free_vec[slot_of(samp_suit, samp_rank)];
    assign scan_ok = free_vec[slot_of(scan_suit_q, scan_rank_q)];

    always_comb begin
        state_d      = state_q;
        try_d        = try_q;
        scan_suit_d  = scan_suit_q;
        scan_rank_d  = scan_rank_q;
        cnt_d        = cnt_q;
        cards_left_d = cards_left_q;
        ack_d        = 1'b0;
        nack_d       = 1'b0;
        suit_d       = suit_q;
        rank_d       = rank_q;
        value_d      = value_q;
        lfsr_d       = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        deal         = 1'b0;
        deal_suit    = samp_suit;
        deal_rank    = samp_rank;
`ifdef CARD_DEALER_STATS_EN
        cyc_d         = cyc_q;
        deal_cycles_d = deal_cycles_q;
        scanned_d     = scanned_q;
        if ((state_q == S_DRAW || state_q == S_SCAN) && cyc_q != 8'hFF) begin
            cyc_d = cyc_q + 8'd1;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!empty_w) begin
                        state_d = S_DRAW;
                        try_d   = '0;
`ifdef CARD_DEALER_STATS_EN
                        cyc_d   = 8'd1;
`endif
                    end else begin
                        nack_d  = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end
            S_DRAW: begin
                if (samp_ok) begin
                    deal = 1'b1;
                end else if (try_q == TRY_LAST) begin
                    state_d     = S_SCAN;
                    scan_suit_d = '0;
                    scan_rank_d = '0;
                end else begin
                    try_d = try_q + 1'b1;
                end
            end
            S_SCAN: begin
                deal_suit = scan_suit_q;
                deal_rank = scan_rank_q;
                if (scan_ok) begin
                    deal = 1'b1;
                end else if (scan_rank_q == RANK_LAST) begin
                    if (scan_suit_q != SUIT_LAST) begin
                        scan_rank_d = '0;
                        scan_suit_d = scan_suit_q + 2'd1;
                    end
                end else begin
                    scan_rank_d = scan_rank_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        deal_idx = slot_of(deal_suit, deal_rank);
        if (deal) begin
            cnt_d[deal_idx] = cnt_q[deal_idx] + 1'b1;
            if (cards_left_q != '0) begin
                cards_left_d = cards_left_q - 1'b1;
            end
            ack_d   = 1'b1;
            suit_d  = deal_suit;
            rank_d  = deal_rank;
            value_d = value_of(deal_rank);
            state_d = S_HOLD;
`ifdef CARD_DEALER_STATS_EN
            deal_cycles_d = cyc_q;
            scanned_d     = (state_q == S_SCAN);
`endif
        end

        // Shuffle overrides everything above, including a deal decided this cycle.
        if (shuffle) begin
            for (int i = 0; i < SLOTS; i++) begin
                cnt_d[i] = '0;
            end
            cards_left_d = CL_W'(TOTAL);
            ack_d        = 1'b0;
            nack_d       = 1'b0;
            suit_d       = '0;
            rank_d       = '0;
            value_d      = '0;
            state_d      = req ? S_HOLD : S_IDLE;
`ifdef CARD_DEALER_STATS_EN
            deal_cycles_d = '0;
            scanned_d     = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            try_q        <= '0;
            scan_suit_q  <= '0;
            scan_rank_q  <= '0;
            lfsr_q       <= LFSR_SEED;
            // NOTE: the use-count array is ordinary flops, not RAM; it must be reset here
            // because an uncleared count would silently remove cards from a fresh shoe.
            for (int i = 0; i < SLOTS; i++) begin
                cnt_q[i] <= '0;
            end
            cards_left_q <= CL_W'(TOTAL);
            ack_q        <= 1'b0;
            nack_q       <= 1'b0;
            suit_q       <= '0;
            rank_q       <= '0;
            value_q      <= '0;
`ifdef CARD_DEALER_STATS_EN
            cyc_q         <= '0;
            deal_cycles_q <= '0;
            scanned_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            try_q        <= try_d;
            scan_suit_q  <= scan_suit_d;
            scan_rank_q  <= scan_rank_d;
            lfsr_q       <= lfsr_d;
            cnt_q        <= cnt_d;
            cards_left_q <= cards_left_d;
            ack_q        <= ack_d;
            nack_q       <= nack_d;
            suit_q       <= suit_d;
            rank_q       <= rank_d;
            value_q      <= value_d;
`ifdef CARD_DEALER_STATS_EN
            cyc_q         <= cyc_d;
            deal_cycles_q <= deal_cycles_d;
            scanned_q     <= scanned_d;
`endif
        end
    end

    assign ack        = ack_q;
    assign nack       = nack_q;
    assign card_suit  = suit_q;
    assign card_rank  = rank_q;
    assign card_value = value_q;
    assign cards_left = cards_left_q;
    assign empty      = empty_w;
    assign busy       = (state_q == S_DRAW) || (state_q == S_SCAN);
`ifdef CARD_DEALER_STATS_EN
    assign deal_cycles = deal_cycles_q;
    assign scanned     = scanned_q;
`endif

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: three instances cover the default shoe, a two-deck
// shoe and a MAX_TRIES=1 shoe that forces the linear-scan fallback.
module tb_card_dealer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic req     [3];
    logic shuffle [3];

    logic       ack_0, nack_0, busy_0, empty_0;
    logic [1:0] suit_0;
    logic [3:0] rank_0, val_0;
    logic [5:0] cl_0;
    logic       ack_1, nack_1, busy_1, empty_1;
    logic [1:0] suit_1;
    logic [3:0] rank_1, val_1;
    logic [6:0] cl_1;
    logic       ack_2, nack_2, busy_2, empty_2;
    logic [1:0] suit_2;
    logic [3:0] rank_2, val_2;
    logic [5:0] cl_2;
`ifdef CARD_DEALER_STATS_EN
    logic [7:0] dc_0, dc_1, dc_2;
    logic [0:0] sc_0, sc_1, sc_2;
`endif

    card_dealer dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .shuffle(shuffle[0]),
        .ack(ack_0), .nack(nack_0), .card_suit(suit_0), .card_rank(rank_0),
        .card_value(val_0), .cards_left(cl_0), .empty(empty_0), .busy(busy_0)
`ifdef CARD_DEALER_STATS_EN
        , .deal_cycles(dc_0), .scanned(sc_0)
`endif
    );

    card_dealer #(.NUM_DECKS(2)) dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .shuffle(shuffle[1]),
        .ack(ack_1), .nack(nack_1), .card_suit(suit_1), .card_rank(rank_1),
        .card_value(val_1), .cards_left(cl_1), .empty(empty_1), .busy(busy_1)
`ifdef CARD_DEALER_STATS_EN
        , .deal_cycles(dc_1), .scanned(sc_1)
`endif
    );

    card_dealer #(.MAX_TRIES(1)) dut2 (
        .clk(clk), .reset(reset), .req(req[2]), .shuffle(shuffle[2]),
        .ack(ack_2), .nack(nack_2), .card_suit(suit_2), .card_rank(rank_2),
        .card_value(val_2), .cards_left(cl_2), .empty(empty_2), .busy(busy_2)
`ifdef CARD_DEALER_STATS_EN
        , .deal_cycles(dc_2), .scanned(sc_2)
`endif
    );

    typedef struct packed {
        logic       ack;
        logic       nack;
        logic       busy;
        logic       empty;
        logic [1:0] suit;
        logic [3:0] rank;
        logic [3:0] value;
        logic [7:0] cl;
        logic       sc;
    } obs_t;

    obs_t obs [3];

    always_comb begin
        obs[0].ack = ack_0; obs[0].nack = nack_0; obs[0].busy = busy_0; obs[0].empty = empty_0;
        obs[0].suit = suit_0; obs[0].rank = rank_0; obs[0].value = val_0; obs[0].cl = {2'b0, cl_0};
        obs[1].ack = ack_1; obs[1].nack = nack_1; obs[1].busy = busy_1; obs[1].empty = empty_1;
        obs[1].suit = suit_1; obs[1].rank = rank_1; obs[1].value = val_1; obs[1].cl = {1'b0, cl_1};
        obs[2].ack = ack_2; obs[2].nack = nack_2; obs[2].busy = busy_2; obs[2].empty = empty_2;
        obs[2].suit = suit_2; obs[2].rank = rank_2; obs[2].value = val_2; obs[2].cl = {2'b0, cl_2};
`ifdef CARD_DEALER_STATS_EN
        obs[0].sc = sc_0[0]; obs[1].sc = sc_1[0]; obs[2].sc = sc_2[0];
`else
        obs[0].sc = 1'b0; obs[1].sc = 1'b0; obs[2].sc = 1'b0;
`endif
    end

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int exp_value(input int r);
        if (r == 0) return 1;
        if (r <= 8) return r + 1;
        return 10;
    endfunction

    // Raise req on instance d, wait up to budget cycles for ack, then drop req.
    // Returns one cycle after the ack so cards_left/empty already reflect the deal.
    task automatic deal(input int d, input int budget, output bit got,
                        output int s, output int r, output int v, output int lat);
        got = 1'b0; s = 0; r = 0; v = 0; lat = 0;
        req[d] = 1'b1;
        for (int c = 1; c <= budget && !got; c++) begin
            @(negedge clk);
            if (obs[d].ack) begin
                got = 1'b1;
                s   = int'(obs[d].suit);
                r   = int'(obs[d].rank);
                v   = int'(obs[d].value);
                lat = c;
                check($sformatf("no_nack_with_ack_d%0d", d), int'(obs[d].nack), 0);
            end
        end
        req[d] = 1'b0;
        check($sformatf("ack_seen_d%0d", d), int'(got), 1);
        @(negedge clk);
        check($sformatf("ack_single_pulse_d%0d", d), int'(obs[d].ack), 0);
    endtask

    bit got;
    int s, r, v, lat, idx, acks, nacks;
    bit seen0 [52];
    bit seen2 [52];
    int use1  [52];

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req[d]     = 1'b0;
            shuffle[d] = 1'b0;
        end
        for (int i = 0; i < 52; i++) begin
            seen0[i] = 1'b0; seen2[i] = 1'b0; use1[i] = 0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack",   int'(obs[0].ack),   0);
        check("rst_nack",  int'(obs[0].nack),  0);
        check("rst_busy",  int'(obs[0].busy),  0);
        check("rst_empty", int'(obs[0].empty), 0);
        check("rst_suit",  int'(obs[0].suit),  0);
        check("rst_rank",  int'(obs[0].rank),  0);
        check("rst_value", int'(obs[0].value), 0);
        check("rst_cl0",   int'(obs[0].cl),    52);
        check("rst_cl1",   int'(obs[1].cl),    104);
        check("rst_cl2",   int'(obs[2].cl),    52);
        reset = 1'b0;
        @(negedge clk);

        // Default shoe: 52 distinct cards, then a nack on the empty shoe
        for (int i = 0; i < 52; i++) begin
            deal(0, 80, got, s, r, v, lat);
            if (got) begin
                check("range0", int'(s < 4 && r < 13), 1);
                if (s < 4 && r < 13) begin
                    idx = s * 13 + r;
                    check("distinct0", int'(seen0[idx]), 0);
                    seen0[idx] = 1'b1;
                end
                check("value0", v, exp_value(r));
            end
            check("cards_left0", int'(obs[0].cl), 51 - i);
        end
        check("empty0_after_52", int'(obs[0].empty), 1);

        req[0] = 1'b1;
        acks = 0; nacks = 0;
        repeat (6) begin
            @(negedge clk);
            acks  += int'(obs[0].ack);
            nacks += int'(obs[0].nack);
        end
        req[0] = 1'b0;
        check("empty_nack_count", nacks, 1);
        check("empty_ack_count",  acks,  0);

        // Shuffle refills the shoe and clears the last card
        shuffle[0] = 1'b1;
        @(negedge clk);
        shuffle[0] = 1'b0;
        check("shuf_cl",    int'(obs[0].cl),    52);
        check("shuf_empty", int'(obs[0].empty), 0);
        check("shuf_suit",  int'(obs[0].suit),  0);
        check("shuf_rank",  int'(obs[0].rank),  0);
        check("shuf_value", int'(obs[0].value), 0);

        // Held req deals once; a fresh req deals again
        for (int k = 0; k < 2; k++) begin
            req[0] = 1'b1;
            acks = 0;
            repeat (80) begin
                @(negedge clk);
                acks += int'(obs[0].ack);
            end
            req[0] = 1'b0;
            @(negedge clk);
            check("held_req_acks", acks, 1);
            check("held_req_cl", int'(obs[0].cl), 51 - k);
        end

        // Shuffle while busy aborts the deal and waits for req to drop
        req[0] = 1'b1;
        @(negedge clk);
        check("busy_after_req", int'(obs[0].busy), 1);
        shuffle[0] = 1'b1;
        @(negedge clk);
        shuffle[0] = 1'b0;
        acks = int'(obs[0].ack);
        repeat (10) begin
            @(negedge clk);
            acks += int'(obs[0].ack);
        end
        check("abort_acks", acks, 0);
        check("abort_busy", int'(obs[0].busy), 0);
        check("abort_cl",   int'(obs[0].cl),   52);
        check("abort_suit", int'(obs[0].suit), 0);
        req[0] = 1'b0;
        @(negedge clk);
        deal(0, 80, got, s, r, v, lat);
        check("after_abort_cl", int'(obs[0].cl), 51);

        // Two-deck shoe: every pair dealt exactly twice
        for (int i = 0; i < 104; i++) begin
            deal(1, 80, got, s, r, v, lat);
            if (got) begin
                check("range1", int'(s < 4 && r < 13), 1);
                if (s < 4 && r < 13) use1[s * 13 + r]++;
                check("value1", v, exp_value(r));
            end
            check("cards_left1", int'(obs[1].cl), 103 - i);
        end
        for (int i = 0; i < 52; i++) begin
            check($sformatf("twice_s%0d_r%0d", i / 13, i % 13), use1[i], 2);
        end
        check("empty1_after_104", int'(obs[1].empty), 1);

        // MAX_TRIES=1: last card must be found within 1 (idle) + 1 (draw) + 52 (scan) cycles
        for (int i = 0; i < 52; i++) begin
            deal(2, 80, got, s, r, v, lat);
            if (got && s < 4 && r < 13) begin
                idx = s * 13 + r;
                check("distinct2", int'(seen2[idx]), 0);
                seen2[idx] = 1'b1;
            end
            check("cards_left2", int'(obs[2].cl), 51 - i);
            if (i == 51) begin
                check("last_card_latency", int'(got && lat <= 1 + 1 + 52), 1);
`ifdef CARD_DEALER_STATS_EN
                // A direct hit acks two cycles after req; anything later went through SCAN
                check("last_card_scanned", int'(obs[2].sc), int'(lat > 2));
`endif
            end
        end
        check("empty2_after_52", int'(obs[2].empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
